mem_arbiter: RTL and testbench

Sequential arbiter that shares the single combinational DPI memory port (pmem_read/pmem_write behind the data-memory datapath) between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the multicycle RV64 core. It accepts one request at a time over valid/ready handshakes, inserts a programmable access latency, and fires exactly one single-cycle memory enable per transaction. It then holds the response until the owning requester accepts it. The block guarantees DPI side effects occur once per transaction, never on idle or reset cycles.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [2:0] MT_B  = 3'b000;
    localparam logic [2:0] MT_H  = 3'b001;
    localparam logic [2:0] MT_W  = 3'b010;
    localparam logic [2:0] MT_D  = 3'b011;
    localparam logic [2:0] MT_BU = 3'b100;
    localparam logic [2:0] MT_HU = 3'b101;
    localparam logic [2:0] MT_WU = 3'b110;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not served last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       i_valid_ifu,
    input  logic       i_valid_lsu,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // o_grant[0] = IFU, o_grant[1] = LSU
    always_comb begin
        o_grant = 2'b00;
        if (i_valid_ifu && i_valid_lsu) begin
            o_grant = (i_last_grant == OWN_IFU) ? 2'b10 : 2'b01;
        end else if (i_valid_ifu) begin
            o_grant = 2'b01;
        end else if (i_valid_lsu) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single combinational memory port between IFU and LSU, one
// transaction at a time, with a programmable wait before the access cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_wen,
    input  logic [63:0] lsu_addr,
    input  logic [2:0]  lsu_mem_type,
    input  logic [63:0] lsu_wdata,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_rdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [2:0]  mem_mem_type,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [7:0] LAT8 = 8'(LATENCY);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_cnt;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_wen;
    logic [63:0] r_addr;
    logic [2:0]  r_mem_type;
    logic [63:0] r_wdata;
    logic [31:0] r_ifu_rdata;
    logic [63:0] r_lsu_rdata;
    logic [1:0]  w_grant;
    logic        w_hs_ifu;
    logic        w_hs_lsu;
    logic        w_hs;
    logic        w_resp_hs;

    rr_arb2 u_rr_arb2 (
        .i_valid_ifu  (ifu_req_valid),
        .i_valid_lsu  (lsu_req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_hs_ifu  = ifu_req_valid & ifu_req_ready;
    assign w_hs_lsu  = lsu_req_valid & lsu_req_ready;
    assign w_hs      = w_hs_ifu | w_hs_lsu;
    assign w_resp_hs = (r_owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next_state = (LATENCY == 0) ? ACCESS : WAIT;
            WAIT:    if (r_cnt <= 8'd1) w_next_state = ACCESS;
            ACCESS:  w_next_state = RESP;
            RESP:    if (w_resp_hs) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Ready and enables are gated by rst so nothing is accepted or fired during reset.
    always_comb begin
        ifu_req_ready  = (r_state == IDLE) & w_grant[0] & ~rst;
        lsu_req_ready  = (r_state == IDLE) & w_grant[1] & ~rst;
        mem_ren        = (r_state == ACCESS) & ~r_wen & ~rst;
        mem_wen        = (r_state == ACCESS) &  r_wen & ~rst;
        ifu_resp_valid = (r_state == RESP) & (r_owner == OWN_IFU);
        lsu_resp_valid = (r_state == RESP) & (r_owner == OWN_LSU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (w_hs) begin
            r_cnt <= LAT8;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_IFU;
            r_wen        <= 1'b0;
            r_addr       <= 64'd0;
            r_mem_type   <= 3'd0;
            r_wdata      <= 64'd0;
            r_ifu_rdata  <= 32'd0;
            r_lsu_rdata  <= 64'd0;
        end else begin
            if (w_hs) begin
                r_owner      <= w_hs_lsu ? OWN_LSU : OWN_IFU;
                r_last_grant <= w_hs_lsu ? OWN_LSU : OWN_IFU;
                r_wen        <= w_hs_lsu & lsu_wen;
                r_addr       <= w_hs_lsu ? lsu_addr : ifu_addr;
                r_mem_type   <= w_hs_lsu ? lsu_mem_type : MT_WU;
                r_wdata      <= w_hs_lsu ? lsu_wdata : 64'd0;
            end
            // Memory data is already extended by the memory model per mem_type.
            if (r_state == ACCESS) begin
                if (r_owner == OWN_IFU) begin
                    r_ifu_rdata <= mem_rdata[31:0];
                end else begin
                    r_lsu_rdata <= r_wen ? 64'd0 : mem_rdata;
                end
            end
        end
    end

    assign mem_addr     = r_addr;
    assign mem_mem_type = r_mem_type;
    assign mem_wdata    = r_wdata;
    assign ifu_rdata    = r_ifu_rdata;
    assign lsu_rdata    = r_lsu_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance at LATENCY=1 with a small
// byte-addressed memory, plus LATENCY=0 and LATENCY=5 instances for timing.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_clr;

    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [63:0] ifu_addr;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [2:0]  lsu_mem_type;
    logic        mem_ren, mem_wen;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_mem_type;

    logic        a_valid, a_resp_ready;
    logic [63:0] a_addr;
    logic        z0_ifu_req_ready, z0_ifu_resp_valid, z0_lsu_req_ready, z0_lsu_resp_valid;
    logic        z0_mem_ren, z0_mem_wen;
    logic [31:0] z0_ifu_rdata;
    logic [63:0] z0_lsu_rdata, z0_mem_addr, z0_mem_wdata;
    logic [2:0]  z0_mem_mem_type;
    logic        z5_ifu_req_ready, z5_ifu_resp_valid, z5_lsu_req_ready, z5_lsu_resp_valid;
    logic        z5_mem_ren, z5_mem_wen;
    logic [31:0] z5_ifu_rdata;
    logic [63:0] z5_lsu_rdata, z5_mem_addr, z5_mem_wdata;
    logic [2:0]  z5_mem_mem_type;

    logic [63:0] mem [0:2047];

    int n_chk = 0;
    int n_err = 0;
    int ren_cnt = 0;
    int wen_cnt = 0;
    int both_cnt = 0;
    logic [63:0] last_w_addr, last_w_data;
    logic [2:0]  last_w_type;

    mem_arbiter #(.LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_mem_type(lsu_mem_type), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_mem_type(mem_mem_type),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(a_valid), .ifu_req_ready(z0_ifu_req_ready), .ifu_addr(a_addr),
        .ifu_resp_valid(z0_ifu_resp_valid), .ifu_resp_ready(a_resp_ready), .ifu_rdata(z0_ifu_rdata),
        .lsu_req_valid(1'b0), .lsu_req_ready(z0_lsu_req_ready), .lsu_wen(1'b0),
        .lsu_addr(64'd0), .lsu_mem_type(3'd0), .lsu_wdata(64'd0),
        .lsu_resp_valid(z0_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(z0_lsu_rdata),
        .mem_ren(z0_mem_ren), .mem_wen(z0_mem_wen), .mem_addr(z0_mem_addr), .mem_mem_type(z0_mem_mem_type),
        .mem_wdata(z0_mem_wdata), .mem_rdata(64'h1111_2222_3333_4444)
    );

    mem_arbiter #(.LATENCY(5)) dut_l5 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(a_valid), .ifu_req_ready(z5_ifu_req_ready), .ifu_addr(a_addr),
        .ifu_resp_valid(z5_ifu_resp_valid), .ifu_resp_ready(a_resp_ready), .ifu_rdata(z5_ifu_rdata),
        .lsu_req_valid(1'b0), .lsu_req_ready(z5_lsu_req_ready), .lsu_wen(1'b0),
        .lsu_addr(64'd0), .lsu_mem_type(3'd0), .lsu_wdata(64'd0),
        .lsu_resp_valid(z5_lsu_resp_valid), .lsu_resp_ready(1'b1), .lsu_rdata(z5_lsu_rdata),
        .mem_ren(z5_mem_ren), .mem_wen(z5_mem_wen), .mem_addr(z5_mem_addr), .mem_mem_type(z5_mem_mem_type),
        .mem_wdata(z5_mem_wdata), .mem_rdata(64'h1111_2222_3333_4444)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rd_ext(input logic [63:0] dw, input logic [2:0] off, input logic [2:0] t);
        logic [63:0] sh;
        sh = dw >> {off, 3'b000};
        case (t)
            3'b000:  rd_ext = {{56{sh[7]}}, sh[7:0]};
            3'b001:  rd_ext = {{48{sh[15]}}, sh[15:0]};
            3'b010:  rd_ext = {{32{sh[31]}}, sh[31:0]};
            3'b011:  rd_ext = sh;
            3'b100:  rd_ext = {56'd0, sh[7:0]};
            3'b101:  rd_ext = {48'd0, sh[15:0]};
            3'b110:  rd_ext = {32'd0, sh[31:0]};
            default: rd_ext = 64'd0;
        endcase
    endfunction

    always_comb mem_rdata = rd_ext(mem[mem_addr[13:3]], mem_addr[2:0], mem_mem_type);

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 64'd0;
            mem[0] <= 64'h0000_0000_0000_0013;
        end else if (mem_wen) begin
            for (int i = 0; i < 8; i++) begin
                if (i < (1 << mem_mem_type[1:0]) && (int'(mem_addr[2:0]) + i) < 8)
                    mem[mem_addr[13:3]][8*(int'(mem_addr[2:0]) + i) +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mem_ren) ren_cnt++;
            if (mem_wen) begin
                wen_cnt++;
                last_w_addr = mem_addr;
                last_w_data = mem_wdata;
                last_w_type = mem_mem_type;
            end
            if (mem_ren && mem_wen) both_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ifu_resp(output logic [31:0] rd);
        int n;
        n = 0;
        while (!ifu_resp_valid && n < 50) begin @(negedge clk); #1; n++; end
        chk("ifu_resp_seen", ifu_resp_valid, 1);
        rd = ifu_rdata;
        ifu_resp_ready = 1'b1;
        @(negedge clk);
        ifu_resp_ready = 1'b0;
        #1;
    endtask

    task automatic ifu_xact(input logic [63:0] a, output logic [31:0] rd);
        int n;
        @(negedge clk);
        ifu_req_valid = 1'b1;
        ifu_addr = a;
        #1;
        n = 0;
        while (!ifu_req_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("ifu_req_hs", ifu_req_ready, 1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        #1;
        wait_ifu_resp(rd);
    endtask

    task automatic lsu_xact(input logic w, input logic [63:0] a, input logic [2:0] t,
                            input logic [63:0] d, output logic [63:0] rd);
        int n;
        @(negedge clk);
        lsu_req_valid = 1'b1;
        lsu_wen = w;
        lsu_addr = a;
        lsu_mem_type = t;
        lsu_wdata = d;
        #1;
        n = 0;
        while (!lsu_req_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk("lsu_req_hs", lsu_req_ready, 1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        #1;
        n = 0;
        while (!lsu_resp_valid && n < 50) begin @(negedge clk); #1; n++; end
        chk("lsu_resp_seen", lsu_resp_valid, 1);
        rd = lsu_rdata;
        lsu_resp_ready = 1'b1;
        @(negedge clk);
        lsu_resp_ready = 1'b0;
        #1;
    endtask

    initial begin
        logic [63:0] rd64;
        logic [31:0] rd32;
        int ren0, wen0, g, n, r0, v0, r5, v5;
        int seq [4];
        int at [4];

        rst = 1'b1; mem_clr = 1'b1;
        ifu_req_valid = 0; ifu_resp_ready = 0; ifu_addr = 64'd0;
        lsu_req_valid = 0; lsu_resp_ready = 0; lsu_wen = 0;
        lsu_addr = 64'd0; lsu_mem_type = 3'd0; lsu_wdata = 64'd0;
        a_valid = 0; a_resp_ready = 1; a_addr = 64'd0;

        // Reset state
        @(negedge clk); @(negedge clk); #1;
        chk("rst_ifu_req_ready", ifu_req_ready, 0);
        chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
        chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_lsu_rdata", lsu_rdata, 0);
        @(negedge clk);
        rst = 1'b0; mem_clr = 1'b0;

        // Single IFU fetch, cycle-exact at LATENCY=1
        wen0 = wen_cnt;
        @(negedge clk);
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000; #1;
        chk("t1_c0_ifu_ready", ifu_req_ready, 1);
        chk("t1_c0_lsu_ready", lsu_req_ready, 0);
        @(negedge clk);
        ifu_req_valid = 1'b0; #1;
        chk("t1_c1_ren", mem_ren, 0);
        chk("t1_c1_resp", ifu_resp_valid, 0);
        @(negedge clk); #1;
        chk("t1_c2_ren", mem_ren, 1);
        chk("t1_c2_wen", mem_wen, 0);
        chk("t1_c2_addr", mem_addr, 64'h8000_0000);
        chk("t1_c2_type", mem_mem_type, 3'b110);
        @(negedge clk);
        ifu_resp_ready = 1'b1; #1;
        chk("t1_c3_resp", ifu_resp_valid, 1);
        chk("t1_c3_rdata", ifu_rdata, 32'h0000_0013);
        chk("t1_c3_ren", mem_ren, 0);
        @(negedge clk);
        ifu_resp_ready = 1'b0; #1;
        chk("t1_c4_resp", ifu_resp_valid, 0);
        chk("t1_c4_rdata_hold", ifu_rdata, 32'h0000_0013);
        chk("t1_no_wen", wen_cnt - wen0, 0);

        // LSU store then load back
        ren0 = ren_cnt; wen0 = wen_cnt;
        lsu_xact(1'b1, 64'h8000_1000, 3'b011, 64'hDEAD_BEEF_CAFE_F00D, rd64);
        chk("st_rdata_zero", rd64, 0);
        chk("st_wen_pulses", wen_cnt - wen0, 1);
        chk("st_ren_pulses", ren_cnt - ren0, 0);
        chk("st_w_addr", last_w_addr, 64'h8000_1000);
        chk("st_w_data", last_w_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("st_w_type", last_w_type, 3'b011);
        chk("st_addr_hold", mem_addr, 64'h8000_1000);
        chk("st_wdata_hold", mem_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        lsu_xact(1'b0, 64'h8000_1000, 3'b011, 64'd0, rd64);
        chk("ld_rdata", rd64, 64'hDEAD_BEEF_CAFE_F00D);
        chk("ld_ren_pulses", ren_cnt - ren0, 1);
        lsu_xact(1'b0, 64'h8000_1004, 3'b010, 64'd0, rd64);
        chk("ld_w_signext", rd64, 64'hFFFF_FFFF_DEAD_BEEF);

        // Both valid from reset: alternation and spacing
        ren0 = ren_cnt; wen0 = wen_cnt;
        @(negedge clk);
        rst = 1'b1;
        ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_1000; lsu_mem_type = 3'b011;
        lsu_resp_ready = 1'b1;
        #1;
        chk("rst_gate_ifu_ready", ifu_req_ready, 0);
        chk("rst_gate_lsu_ready", lsu_req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        g = 0; n = 0;
        while (g < 4 && n < 40) begin
            #1;
            if (ifu_req_ready || lsu_req_ready) begin
                chk("alt_one_ready", ifu_req_ready & lsu_req_ready, 0);
                seq[g] = lsu_req_ready ? 1 : 0;
                at[g] = n;
                g++;
            end
            if (g < 4) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (6) @(negedge clk);
        ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
        #1;
        chk("alt_grants", g, 4);
        chk("alt_g0_lsu", seq[0], 1);
        chk("alt_g1_ifu", seq[1], 0);
        chk("alt_g2_lsu", seq[2], 1);
        chk("alt_g3_ifu", seq[3], 0);
        chk("alt_spacing", at[1] - at[0], 4);
        chk("alt_ren_total", ren_cnt - ren0, 4);
        chk("alt_no_wen", wen_cnt - wen0, 0);
        chk("alt_no_both", both_cnt, 0);

        // Held LSU response blocks the IFU until its handshake
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 64'h8000_1000; lsu_mem_type = 3'b011;
        #1;
        chk("hold_lsu_ready", lsu_req_ready, 1);
        @(negedge clk);
        lsu_req_valid = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0000; #1;
        chk("hold_wait_ifu_ready", ifu_req_ready, 0);
        @(negedge clk); #1;
        chk("hold_access_ren", mem_ren, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("hold_resp_valid", lsu_resp_valid, 1);
            chk("hold_rdata", lsu_rdata, 64'hDEAD_BEEF_CAFE_F00D);
            chk("hold_ifu_blocked", ifu_req_ready, 0);
        end
        @(negedge clk);
        lsu_resp_ready = 1'b1; #1;
        chk("hold_hs_ifu_ready", ifu_req_ready, 0);
        @(negedge clk);
        lsu_resp_ready = 1'b0; #1;
        chk("hold_after_ifu_ready", ifu_req_ready, 1);
        chk("hold_after_resp", lsu_resp_valid, 0);
        chk("hold_after_rdata", lsu_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        @(negedge clk);
        ifu_req_valid = 1'b0; #1;
        wait_ifu_resp(rd32);
        chk("hold_ifu_rdata", rd32, 32'h0000_0013);

        // LATENCY=0 and LATENCY=5 timing
        r0 = -1; v0 = -1; r5 = -1; v5 = -1;
        @(negedge clk);
        a_valid = 1'b1; a_addr = 64'h8000_0040; #1;
        chk("l0_ready", z0_ifu_req_ready, 1);
        chk("l5_ready", z5_ifu_req_ready, 1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) a_valid = 1'b0;
            #1;
            if (z0_mem_ren && r0 < 0) r0 = c;
            if (z0_ifu_resp_valid && v0 < 0) v0 = c;
            if (z5_mem_ren && r5 < 0) r5 = c;
            if (z5_ifu_resp_valid && v5 < 0) v5 = c;
        end
        chk("l0_ren_cycle", r0, 1);
        chk("l0_resp_cycle", v0, 2);
        chk("l5_ren_cycle", r5, 6);
        chk("l5_resp_cycle", v5, 7);
        chk("l0_rdata", z0_ifu_rdata, 32'h3333_4444);
        chk("l5_rdata", z5_ifu_rdata, 32'h3333_4444);

        // Reset during WAIT
        wen0 = wen_cnt;
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_0200;
        lsu_mem_type = 3'b011; lsu_wdata = 64'h1234; #1;
        chk("rw_ready", lsu_req_ready, 1);
        @(negedge clk);
        lsu_req_valid = 1'b0; rst = 1'b1; #1;
        chk("rw_wen_in_rst", mem_wen, 0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rw_mem_addr", mem_addr, 0);
        chk("rw_mem_wdata", mem_wdata, 0);
        chk("rw_mem_type", mem_mem_type, 0);
        chk("rw_resp", lsu_resp_valid, 0);
        repeat (4) @(negedge clk);
        #3;
        chk("rw_no_wen", wen_cnt - wen0, 0);

        // Reset during ACCESS
        @(negedge clk);
        lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h8000_0100;
        lsu_mem_type = 3'b011; lsu_wdata = 64'h5555; #1;
        chk("ra_ready", lsu_req_ready, 1);
        @(negedge clk);
        lsu_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        chk("ra_wen_in_rst", mem_wen, 0);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("ra_resp", lsu_resp_valid, 0);
        chk("ra_lsu_rdata", lsu_rdata, 0);
        chk("ra_ifu_rdata", ifu_rdata, 0);
        chk("ra_mem_wdata", mem_wdata, 0);
        repeat (4) @(negedge clk);
        #3;
        chk("ra_no_wen", wen_cnt - wen0, 0);
        lsu_xact(1'b0, 64'h8000_0100, 3'b011, 64'd0, rd64);
        chk("ra_mem_untouched", rd64, 0);
        lsu_xact(1'b0, 64'h8000_0200, 3'b011, 64'd0, rd64);
        chk("rw_mem_untouched", rd64, 0);
        ifu_xact(64'h8000_0000, rd32);
        chk("post_rst_fetch", rd32, 32'h0000_0013);
        chk("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
